// File: rtl/somador_pkg.sv
// rtl/somador_pkg.sv - shared opcodes and pipeline geometry helpers for the sliced adder
package somador_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int stages(input int width, input int slice);
    return width / slice;
  endfunction

  // Geometry must split into whole slices with at least one stage.
  function automatic bit geometry_ok(input int width, input int slice);
    return (slice > 0) && (width >= slice) && ((width % slice) == 0);
  endfunction

endpackage

// File: rtl/somador_fa.sv
// rtl/somador_fa.sv - one-bit full-adder cell
module somador_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/somador_fatia.sv
// rtl/somador_fatia.sv - combinational SLICE-bit ripple adder built from full-adder cells
module somador_fatia #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] s,
  output logic             cout
);

  logic [SLICE:0] w_c;

  assign w_c[0] = cin;

  for (genvar i = 0; i < SLICE; i++) begin : g_bit
    somador_fa u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .cin (w_c[i]),
      .s   (s[i]),
      .cout(w_c[i+1])
    );
  end

  assign cout = w_c[SLICE];

endmodule

// File: rtl/somador_pipeline_param.sv
// rtl/somador_pipeline_param.sv - pipelined add/sub, one SLICE per stage, valid/ready handshake
// Optional overflow output ovf when SOMADOR_OVF_EN is defined.
module somador_pipeline_param
  import somador_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   S
`ifdef SOMADOR_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int STAGES = stages(WIDTH, SLICE);
  localparam int LAST   = STAGES - 1;

  if (!geometry_ok(WIDTH, SLICE)) begin : g_bad_geometry
    $error("somador_pipeline_param: WIDTH must be a positive multiple of SLICE");
  end

  logic             w_advance;
  logic             r_vld [STAGES];
  logic             r_sub [STAGES];
  logic             r_cy  [STAGES];
  logic [WIDTH-1:0] r_a   [STAGES];
  logic [WIDTH-1:0] r_b   [STAGES];
  logic [WIDTH-1:0] r_sum [STAGES];

  logic             w_vld_in  [STAGES];
  logic             w_sub_in  [STAGES];
  logic             w_cin     [STAGES];
  logic [WIDTH-1:0] w_a_in    [STAGES];
  logic [WIDTH-1:0] w_b_in    [STAGES];
  logic [WIDTH-1:0] w_sum_in  [STAGES];
  logic [WIDTH-1:0] w_sum_nxt [STAGES];
  logic [SLICE-1:0] w_s       [STAGES];
  logic             w_cout    [STAGES];

  assign w_advance = !r_vld[LAST] || out_ready;
  assign in_ready  = w_advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      // Subtraction becomes A + ~B + 1 here; later stages only see effective operands.
      assign w_vld_in[k] = in_valid;
      assign w_sub_in[k] = (sub == OP_SUB);
      assign w_cin[k]    = (sub == OP_SUB);
      assign w_a_in[k]   = A;
      assign w_b_in[k]   = (sub == OP_SUB) ? ~B : B;
      assign w_sum_in[k] = '0;
    end else begin : g_body
      assign w_vld_in[k] = r_vld[k-1];
      assign w_sub_in[k] = r_sub[k-1];
      assign w_cin[k]    = r_cy[k-1];
      assign w_a_in[k]   = r_a[k-1];
      assign w_b_in[k]   = r_b[k-1];
      assign w_sum_in[k] = r_sum[k-1];
    end

    somador_fatia #(.SLICE(SLICE)) u_fatia (
      .a   (w_a_in[k][k*SLICE +: SLICE]),
      .b   (w_b_in[k][k*SLICE +: SLICE]),
      .cin (w_cin[k]),
      .s   (w_s[k]),
      .cout(w_cout[k])
    );

    // Bits above the current slice are still zero, so OR merges the new slice in place.
    assign w_sum_nxt[k] = w_sum_in[k] | (WIDTH'(w_s[k]) << (k*SLICE));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        r_vld[k] <= 1'b0;
        r_sub[k] <= 1'b0;
        r_cy[k]  <= 1'b0;
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_sum[k] <= '0;
      end
    end else if (w_advance) begin
      for (int k = 0; k < STAGES; k++) begin
        r_vld[k] <= w_vld_in[k];
        r_sub[k] <= w_sub_in[k];
        r_cy[k]  <= w_cout[k];
        r_a[k]   <= w_a_in[k];
        r_b[k]   <= w_b_in[k];
        r_sum[k] <= w_sum_nxt[k];
      end
    end
  end

  assign out_valid = r_vld[LAST];
  // Carry out of A + ~B + 1 is the inverse of borrow, hence the XOR with sub.
  assign S = {r_cy[LAST] ^ r_sub[LAST], r_sum[LAST]};

`ifdef SOMADOR_OVF_EN
  logic w_msb_cin;
  logic w_ovf_nxt;
  logic r_ovf;

  assign w_msb_cin = w_a_in[LAST][WIDTH-1] ^ w_b_in[LAST][WIDTH-1] ^ w_s[LAST][SLICE-1];
  assign w_ovf_nxt = w_msb_cin ^ w_cout[LAST];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_advance) begin
      r_ovf <= w_ovf_nxt;
    end
  end

  assign ovf = r_ovf;
`endif

endmodule
